hit_judge: RTL and testbench

HIT_JUDGE -- requirements
Module: hit_judge

---
 rtl/hit_judge.sv | 151 +++++++++++++++
 tb/tb_hit_judge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_judge.sv
// Rhythm-game hit judge: synchronizes the don/ka keys, turns presses into
// one-cycle pulses and judges them against the note currently at the hit
// position, keeping a saturating BCD score and a saturating combo counter.
module hit_judge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COMBO_W     = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [1:0]         note_in,
  input  logic               note_step,
  input  logic               key_don_n,
  input  logic               key_ka_n,
  output logic [7:0]         score_bcd,
  output logic [COMBO_W-1:0] combo,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [1:0]         state
);

  localparam int unsigned SCORE_W = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'h99;
  localparam logic [COMBO_W-1:0] COMBO_MAX = {COMBO_W{1'b1}};

  typedef enum logic [1:0] {
    REST  = 2'b00,
    ARMED = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Key conditioning: bit 0 = don, bit 1 = ka
  logic [SYNC_STAGES-1:0] don_sync_q, don_sync_d;
  logic [SYNC_STAGES-1:0] ka_sync_q, ka_sync_d;
  logic [1:0]             edge_q, edge_d;
  logic [1:0]             press_q, press_d;
  logic [1:0]             sync_last;

  // Judge state
  state_e             state_q, state_d;
  logic [1:0]         note_q, note_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic don_p, ka_p;
  logic judged, match;

  // Synchronizer shift and falling-edge detect (a press is released->pressed)
  always_comb begin
    sync_last  = {ka_sync_q[SYNC_STAGES-1], don_sync_q[SYNC_STAGES-1]};
    don_sync_d = SYNC_STAGES'({don_sync_q, key_don_n});
    ka_sync_d  = SYNC_STAGES'({ka_sync_q, key_ka_n});
    edge_d     = sync_last;
    press_d    = edge_q & ~sync_last;
  end

  // Key path registers; reset loads "released" so leaving reset never presses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      don_sync_q <= '1;
      ka_sync_q  <= '1;
      edge_q     <= 2'b11;
      press_q    <= 2'b00;
    end else begin
      don_sync_q <= don_sync_d;
      ka_sync_q  <= ka_sync_d;
      edge_q     <= edge_d;
      press_q    <= press_d;
    end
  end

  // Judge the armed note (press first, else expiry on note_step), then latch
  // the next note; a same-cycle press is judged against the old note.
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    score_d = score_q;
    combo_d = combo_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    judged  = 1'b0;
    match   = 1'b0;
    don_p   = press_q[0];
    ka_p    = press_q[1];

    if (state_q == ARMED) begin
      if (don_p || ka_p) begin
        judged = 1'b1;
        unique case (note_q)
          2'b01:   match = don_p & ~ka_p;
          2'b10:   match = ka_p & ~don_p;
          default: match = 1'b1;
        endcase
      end else if (note_step) begin
        judged = 1'b1;
      end
    end

    if (judged) begin
      state_d = DONE;
      hit_d   = match;
      miss_d  = ~match;
      if (match) begin
        if (score_q != SCORE_MAX) begin
          if (score_q[3:0] == 4'd9) begin
            score_d = {score_q[7:4] + 4'd1, 4'd0};
          end else begin
            score_d = {score_q[7:4], score_q[3:0] + 4'd1};
          end
        end
        if (combo_q != COMBO_MAX) begin
          combo_d = combo_q + COMBO_W'(1);
        end
      end else begin
        combo_d = '0;
      end
    end

    if (note_step) begin
      note_d  = note_in;
      state_d = (note_in != 2'b00) ? ARMED : REST;
    end
  end

  // Judge state and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= REST;
      note_q  <= 2'b00;
      score_q <= '0;
      combo_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      score_q <= score_d;
      combo_q <= combo_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign score_bcd  = score_q;
  assign combo      = combo_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign state      = state_q;

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: stimulus pushes expected strobes, a
// monitor branch pops and compares on every hit/miss strobe.
module tb_hit_judge;

  localparam int unsigned S  = 2;
  localparam int unsigned CW = 8;
  localparam logic [1:0] ST_REST  = 2'b00;
  localparam logic [1:0] ST_ARMED = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    note_in;
  logic          note_step;
  logic          key_don_n;
  logic          key_ka_n;
  logic [7:0]    score_bcd;
  logic [CW-1:0] combo;
  logic          hit_pulse;
  logic          miss_pulse;
  logic [1:0]    state;

  hit_judge #(.SYNC_STAGES(S), .COMBO_W(CW)) dut (
    .clk(clk), .resetn(resetn), .note_in(note_in), .note_step(note_step),
    .key_don_n(key_don_n), .key_ka_n(key_ka_n), .score_bcd(score_bcd),
    .combo(combo), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         hit;
    logic [7:0] score;
    logic [7:0] cmb;
    logic [1:0] st;
    int         at;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cnt = 0;
  int cmb = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] to_bcd(int c);
    logic [3:0] t, u;
    t = 4'(c / 10);
    u = 4'(c % 10);
    return {t, u};
  endfunction

  task automatic push_hit(logic [1:0] st, int at);
    exp_t e;
    if (cnt < 99) cnt++;
    if (cmb < 255) cmb++;
    e.hit = 1'b1; e.score = to_bcd(cnt); e.cmb = 8'(cmb); e.st = st; e.at = at;
    q.push_back(e);
  endtask

  task automatic push_miss(logic [1:0] st);
    exp_t e;
    cmb = 0;
    e.hit = 1'b0; e.score = to_bcd(cnt); e.cmb = 8'(cmb); e.st = st; e.at = -1;
    q.push_back(e);
  endtask

  // All stimulus tasks start and end at a falling edge
  task automatic step(logic [1:0] n);
    note_in = n;
    note_step = 1'b1;
    @(negedge clk);
    note_step = 1'b0;
  endtask

  task automatic press(bit don, bit ka, int hold);
    key_don_n = ~don;
    key_ka_n  = ~ka;
    repeat (hold) @(negedge clk);
    key_don_n = 1'b1;
    key_ka_n  = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic hit_note(logic [1:0] n, bit don, bit ka);
    step(n);
    push_hit(ST_DONE, -1);
    press(don, ka, 5);
  endtask

  task automatic drained(string nm);
    chk({nm, "_pending"}, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic monitor_step();
    exp_t e;
    if (hit_pulse === 1'b1 || miss_pulse === 1'b1) begin
      chk("strobe_exclusive", {31'd0, hit_pulse & miss_pulse}, 32'd0);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got hit=%0b miss=%0b expected none (cycle %0d)",
                 hit_pulse, miss_pulse, cyc);
      end else begin
        e = q.pop_front();
        chk("strobe_kind_hit", {31'd0, hit_pulse}, {31'd0, e.hit});
        chk("strobe_score", {24'd0, score_bcd}, {24'd0, e.score});
        chk("strobe_combo", {24'd0, combo}, {24'd0, e.cmb});
        chk("strobe_state", {30'd0, state}, {30'd0, e.st});
        if (e.at >= 0) chk("strobe_latency", 32'(cyc), 32'(e.at));
      end
    end
  endtask

  task automatic check_reset_outputs(string nm);
    chk({nm, "_score"}, {24'd0, score_bcd}, 32'h0);
    chk({nm, "_combo"}, {24'd0, combo}, 32'h0);
    chk({nm, "_state"}, {30'd0, state}, {30'd0, ST_REST});
    chk({nm, "_hit"}, {31'd0, hit_pulse}, 32'd0);
    chk({nm, "_miss"}, {31'd0, miss_pulse}, 32'd0);
  endtask

  task automatic run_tests();
    int pc;
    int c0;
    // Reset
    resetn = 1'b0; note_in = 2'b00; note_step = 1'b0;
    key_don_n = 1'b1; key_ka_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("post_reset");

    // Don note, don held 5 cycles: one hit at SYNC_STAGES+2
    step(2'b01);
    chk("t1_armed", {30'd0, state}, {30'd0, ST_ARMED});
    push_hit(ST_DONE, cyc + int'(S) + 2);
    press(1'b1, 1'b0, 5);
    chk("t1_score", {24'd0, score_bcd}, 32'h01);
    chk("t1_combo", {24'd0, combo}, 32'd1);
    chk("t1_state", {30'd0, state}, {30'd0, ST_DONE});
    drained("t1");

    // Ka note, wrong key; later ka press in DONE ignored
    step(2'b10);
    push_miss(ST_DONE);
    press(1'b1, 1'b0, 5);
    press(1'b0, 1'b1, 5);
    chk("t2_score", {24'd0, score_bcd}, 32'h01);
    chk("t2_combo", {24'd0, combo}, 32'd0);
    drained("t2");

    // Armed note expires on next step with a rest note
    step(2'b01);
    push_miss(ST_REST);
    step(2'b00);
    @(negedge clk);
    chk("t3_state", {30'd0, state}, {30'd0, ST_REST});
    press(1'b1, 1'b0, 3);
    drained("t3");

    // Decimal carry 09 -> 10
    for (int i = 0; i < 8; i++) hit_note(2'b01, 1'b1, 1'b0);
    chk("t4_score09", {24'd0, score_bcd}, 32'h09);
    hit_note(2'b10, 1'b0, 1'b1);
    chk("t4_score10", {24'd0, score_bcd}, 32'h10);
    chk("t4_combo", {24'd0, combo}, 32'd9);
    drained("t4");

    // Fill to 99, then one more hit saturates score but bumps combo
    for (int i = 0; cnt < 99; i++) begin
      case (i % 3)
        0: hit_note(2'b01, 1'b1, 1'b0);
        1: hit_note(2'b10, 1'b0, 1'b1);
        default: hit_note(2'b11, 1'b0, 1'b1);
      endcase
    end
    chk("t5_score99", {24'd0, score_bcd}, 32'h99);
    chk("t5_combo98", {24'd0, combo}, 32'd98);
    hit_note(2'b11, 1'b1, 1'b0);
    chk("t5_score_sat", {24'd0, score_bcd}, 32'h99);
    chk("t5_combo99", {24'd0, combo}, 32'd99);
    drained("t5");

    // Combo saturates at 255
    while (cmb < 255) hit_note(2'b01, 1'b1, 1'b0);
    hit_note(2'b10, 1'b0, 1'b1);
    chk("t6_combo_sat", {24'd0, combo}, 32'd255);
    drained("t6");

    // Big note with both keys together: a single hit
    step(2'b11);
    push_hit(ST_DONE, -1);
    press(1'b1, 1'b1, 5);
    drained("t7");

    // Don note with both keys together: miss
    step(2'b01);
    push_miss(ST_DONE);
    press(1'b1, 1'b1, 5);
    chk("t8_combo", {24'd0, combo}, 32'd0);
    drained("t8");

    // Press coincident with note_step: hit on old note, new note latched
    step(2'b01);
    key_don_n = 1'b0;
    pc = cyc;
    push_hit(ST_ARMED, pc + int'(S) + 2);
    repeat (int'(S) + 1) @(negedge clk);
    step(2'b10);
    chk("t9_armed", {30'd0, state}, {30'd0, ST_ARMED});
    repeat (2) @(negedge clk);
    key_don_n = 1'b1;
    repeat (6) @(negedge clk);
    push_hit(ST_DONE, -1);
    press(1'b0, 1'b1, 5);
    chk("t9_combo", {24'd0, combo}, 32'd2);
    drained("t9");

    // Reset while armed: no strobe, reset values, judging resumes after
    step(2'b01);
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("t10_in_reset");
    resetn = 1'b1;
    cnt = 0;
    cmb = 0;
    c0 = 0;
    repeat (4) begin
      @(negedge clk);
      if (state != ST_REST) c0++;
    end
    chk("t10_stays_rest", 32'(c0), 32'd0);
    press(1'b1, 1'b0, 5);
    check_reset_outputs("t10_after");
    drained("t10");
    hit_note(2'b01, 1'b1, 1'b0);
    chk("t10_score", {24'd0, score_bcd}, 32'h01);
    chk("t10_combo", {24'd0, combo}, 32'd1);
    drained("t10_resume");
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      run_tests();
      begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got no completion expected finish within 100000 cycles");
        $fatal(1, "watchdog");
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
